ledger_arbiter: RTL and testbench
=================================

LEDGER_ARBITER -- requirements
Module: ledger_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the account-ledger address width (16 accounts).
REQ-002 Parameter DATA_W, default 16, SHALL set the ledger word width (balance units).
REQ-003 Parameter LOCK_TIMEOUT, default 255, SHALL set the idle-cycle limit on a held lock.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 reqN_valid  in  1  (N=0 transaction port, N=1 report/UART port) request present.
REQ-007 reqN_we  in  1  1 = write, 0 = read.
REQ-008 reqN_addr  in  ADDR_W  ledger address.
REQ-009 reqN_wdata  in  DATA_W  write data.
REQ-010 reqN_lock  in  1  keep grant after this beat (atomic read-modify-write/transfer).
REQ-011 reqN_ready  out  1  beat accepted this cycle when reqN_valid is also high.
REQ-012 reqN_rvalid  out  1  one-cycle pulse, read data valid.
REQ-013 reqN_rdata  out  DATA_W  read data, held until the next rvalid for that port.
REQ-014 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  registered single-port ledger command.
REQ-015 mem_rdata  in  DATA_W  ledger read data, one cycle after mem_en with mem_we=0.
REQ-016 lock_abort  out  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-017 At most one beat SHALL be accepted per cycle; reqN_ready is a combinational function of valids, rr pointer, and lock state.
REQ-018 With no lock held, both valid: the port not granted last SHALL win (round-robin); one valid: it wins.
REQ-019 An accepted beat in cycle T SHALL drive mem_* in cycle T+1; read data SHALL appear on reqN_rdata with reqN_rvalid in T+2.
REQ-020 Back-to-back beats SHALL be accepted every cycle; read returns SHALL be routed in issue order by a 2-deep owner tag pipeline.
REQ-021 State machine: IDLE (no lock) -> LOCK0/LOCK1 on acceptance of a beat with reqN_lock=1; LOCKn -> IDLE on acceptance of a port-n beat with lock=0, or on timeout.
REQ-022 In LOCKn the other port's ready SHALL be 0 regardless of its valid.
REQ-023 rr pointer SHALL update only on an accepted beat; mem_en SHALL be 0 in cycles following no acceptance.
REQ-024 Reads and writes to the same address in consecutive cycles SHALL be issued in acceptance order; the arbiter adds no forwarding.

Reset
REQ-025 rst_n low SHALL immediately clear all outputs to 0, state to IDLE, rr pointer to favour port 0, owner tags and timeout counter to 0.
REQ-026 Reset mid-lock or with reads in flight SHALL discard them; no rvalid SHALL follow reset deassertion until a new read is accepted.

Configuration
REQ-027 Macro LEDGER_ARB_TIMEOUT_EN defined: in LOCKn a counter SHALL count cycles without a port-n acceptance, reset on each port-n acceptance; reaching LOCK_TIMEOUT SHALL return to IDLE and pulse lock_abort.
REQ-028 Macro undefined: no counter; locks release only per REQ-021; lock_abort tied to 0.

Structure
REQ-029 Package ledger_arb_pkg SHALL hold ADDR_W/DATA_W defaults, LOCK_TIMEOUT default and the state enumeration (IDLE, LOCK0, LOCK1).
REQ-030 Sub-module rr_pick2 SHALL implement the two-way round-robin pick (valids, pointer -> one-hot grant).

Verification
REQ-031 Port 0 read addr 3 (mem holds 0x0064) alone -> mem_en=1, mem_we=0, mem_addr=3 at T+1; req0_rvalid=1, req0_rdata=0x0064 at T+2.
REQ-032 Both valid every cycle, no lock, from reset -> grants 0,1,0,1 on consecutive cycles.
REQ-033 Port 0 read addr 2 lock=1, write addr 2 0x0032 lock=0; port 1 valid throughout -> req1_ready=0 until port 0's write is accepted, then port 1 granted next cycle.
REQ-034 LEDGER_ARB_TIMEOUT_EN, LOCK_TIMEOUT=4, port 0 locks then goes idle -> lock_abort pulses 4 cycles after the lock beat; port 1 granted the following cycle.
REQ-035 rst_n asserted one cycle after a read is accepted -> all outputs 0, no rvalid after release.
REQ-036 Port 0 write addr 5 0x00AA then port 1 read addr 5 next cycle -> req1_rdata=0x00AA.

Source files
------------

// File: rtl/ledger_arb_pkg.sv
// Shared defaults and the lock-state encoding for the two-port ledger arbiter.
package ledger_arb_pkg;

    localparam int ADDR_W_DEF       = 4;
    localparam int DATA_W_DEF       = 16;
    localparam int LOCK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    function automatic arb_state_t lock_state(input logic port);
        return port ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: prio names the port that wins a tie.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (valid[0] && valid[1]) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/ledger_arbiter.sv
// Two-port arbiter in front of a single-port account ledger, with lockable grants.
// Define LEDGER_ARB_TIMEOUT_EN to add the idle-lock timeout and lock_abort pulse.
module ledger_arbiter
    import ledger_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_abort
);

    arb_state_t        state;
    logic              prio;
    logic [1:0]        valid;
    logic [1:0]        pick;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              tag1_v, tag1_o;
    logic              tag2_v, tag2_o;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              timeout;

    assign valid = {req1_valid, req0_valid};

    rr_pick2 u_pick (
        .valid (valid),
        .prio  (prio),
        .grant (pick)
    );

    // A held lock shuts the other port out entirely.
    always_comb begin
        grant = 2'b00;
        case (state)
            IDLE:    grant = pick;
            LOCK0:   grant[0] = valid[0];
            LOCK1:   grant[1] = valid[1];
            default: grant = 2'b00;
        endcase
    end

    assign ready      = grant & {2{rst_n}};
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    assign accept    = |ready;
    assign sel       = ready[1];
    assign sel_we    = sel ? req1_we    : req0_we;
    assign sel_lock  = sel ? req1_lock  : req0_lock;
    assign sel_addr  = sel ? req1_addr  : req0_addr;
    assign sel_wdata = sel ? req1_wdata : req0_wdata;

`ifdef LEDGER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [CNT_W-1:0] idle_cnt;

    // Fires on the LOCK_TIMEOUT-th consecutive locked cycle without an owner beat.
    assign timeout = (state != IDLE) && !accept && (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == IDLE || accept || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign lock_abort = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            prio  <= ~sel;
            state <= sel_lock ? lock_state(sel) : IDLE;
        end else if (timeout) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tag1_v    <= 1'b0;
            tag1_o    <= 1'b0;
            tag2_v    <= 1'b0;
            tag2_o    <= 1'b0;
            // NOTE: the ledger array is external; only the read-hold registers here are reset.
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            mem_en    <= accept;
            mem_we    <= accept & sel_we;
            mem_addr  <= accept ? sel_addr : '0;
            mem_wdata <= (accept && sel_we) ? sel_wdata : '0;
            tag1_v    <= accept & ~sel_we;
            tag1_o    <= sel;
            tag2_v    <= tag1_v;
            tag2_o    <= tag1_o;
            if (req0_rvalid) rdata0_q <= mem_rdata;
            if (req1_rvalid) rdata1_q <= mem_rdata;
        end
    end

    // Read data lands on the port in the same cycle the ledger returns it.
    assign req0_rvalid = tag2_v & ~tag2_o;
    assign req1_rvalid = tag2_v & tag2_o;
    assign req0_rdata  = req0_rvalid ? mem_rdata : rdata0_q;
    assign req1_rdata  = req1_rvalid ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_ledger_arbiter.sv
// Directed bench for ledger_arbiter with a behavioural ledger and an in-order read scoreboard.
module tb_ledger_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
    logic [3:0]  req0_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
    logic [3:0]  req1_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic        mem_en, mem_we, lock_abort;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    logic [15:0] ledger [16];
    logic [1:0]  rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    ledger_arbiter #(.ADDR_W(4), .DATA_W(16), .LOCK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_lock   (req0_lock),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_lock   (req1_lock),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .lock_abort  (lock_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ledger[mem_addr] <= mem_wdata;
            else        mem_rdata <= ledger[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (req0_rvalid || req1_rvalid) begin
            if (sb.size() == 0) begin
                check("spurious_rvalid", {req1_rvalid, req0_rvalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid_port", {req1_rvalid, req0_rvalid}, e.port ? 2'b10 : 2'b01);
                check("rdata", e.port ? req1_rdata : req0_rdata, e.data);
            end
        end
    end

    task automatic push(input logic p, input logic [15:0] d);
        sb.push_back('{port: p, data: d});
    endtask

    task automatic drive0(input logic v, input logic we, input logic [3:0] a,
                          input logic [15:0] d, input logic lk);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_lock = lk;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [3:0] a,
                          input logic [15:0] d, input logic lk);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_lock = lk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string name, input logic [1:0] exp);
        @(negedge clk);
        check(name, {req1_ready, req0_ready}, exp);
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {req0_ready, req0_rvalid, req1_ready, req1_rvalid,
                               mem_en, mem_we, lock_abort}, 7'b0);
        check({name, "_mem"}, {mem_addr, mem_wdata}, 20'h0);
        check({name, "_rdata"}, {req0_rdata, req1_rdata}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ledger[i] = 16'h0;
        ledger[0] = 16'h1111;
        ledger[1] = 16'h2222;
        ledger[2] = 16'h0010;
        ledger[3] = 16'h0064;
        ledger[4] = 16'h0404;
        rst_n = 1'b0;
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;

        // Single read on port 0, then latency checks.
        drive0(1, 0, 4'd3, 0, 0);
        check_ready("single_read_ready", 2'b01);
        push(1'b0, 16'h0064);
        tick();
        drive0(0, 0, 0, 0, 0);
        @(negedge clk);
        check("single_read_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 4'd3});
        tick();
        @(negedge clk);
        check("single_read_rvalid_t2", req0_rvalid, 1'b1);
        check("mem_en_after_idle", mem_en, 1'b0);
        tick();

        // Round-robin from reset with both ports always valid.
        do_reset();
        drive0(1, 0, 4'd0, 0, 0);
        drive1(1, 0, 4'd1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            check_ready("rr_grant", rr_exp[k]);
            if (rr_exp[k] == 2'b01) push(1'b0, 16'h1111);
            else                    push(1'b1, 16'h2222);
            tick();
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Lock on port 0 blocks port 1 until the unlocking write.
        drive0(1, 0, 4'd2, 0, 1);
        drive1(1, 0, 4'd4, 0, 0);
        check_ready("lock_beat", 2'b01);
        push(1'b0, 16'h0010);
        tick();
        drive0(0, 0, 0, 0, 0);
        check_ready("lock_blocks_p1", 2'b00);
        tick();
        drive0(1, 1, 4'd2, 16'h0032, 0);
        check_ready("unlock_write", 2'b01);
        tick();
        drive0(0, 0, 0, 0, 0);
        check_ready("p1_after_unlock", 2'b10);
        push(1'b1, 16'h0404);
        tick();
        drive1(0, 0, 0, 0, 0);
        drive0(1, 0, 4'd2, 0, 0);
        check_ready("readback_ready", 2'b01);
        push(1'b0, 16'h0032);
        tick();
        drive0(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Write then read of the same address in consecutive cycles.
        drive0(1, 1, 4'd5, 16'h00AA, 0);
        check_ready("raw_write", 2'b01);
        tick();
        drive0(0, 0, 0, 0, 0);
        drive1(1, 0, 4'd5, 0, 0);
        check_ready("raw_read", 2'b10);
        check("raw_write_cmd", {mem_en, mem_we, mem_addr, mem_wdata},
              {1'b1, 1'b1, 4'd5, 16'h00AA});
        push(1'b1, 16'h00AA);
        tick();
        drive1(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset with a read in flight discards it.
        drive0(1, 0, 4'd3, 0, 0);
        check_ready("flush_read", 2'b01);
        tick();
        drive0(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_rvalid_after_reset", {req1_rvalid, req0_rvalid}, 2'b00);
            tick();
        end

        do_reset();
        drive0(1, 0, 4'd3, 0, 1);
        drive1(1, 0, 4'd1, 0, 0);
        check_ready("idle_lock_beat", 2'b01);
        push(1'b0, 16'h0064);
        tick();
        drive0(0, 0, 0, 0, 0);
`ifdef LEDGER_ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            check_ready("timeout_wait_ready", 2'b00);
            check("timeout_wait_abort", lock_abort, 1'b0);
            tick();
        end
        check_ready("timeout_ready", 2'b00);
        check("timeout_abort", lock_abort, 1'b1);
        tick();
        check_ready("after_abort_p1", 2'b10);
        check("after_abort_pulse_end", lock_abort, 1'b0);
        push(1'b1, 16'h2222);
        tick();
        drive1(0, 0, 0, 0, 0);
`else
        for (int k = 0; k < 8; k++) begin
            check_ready("lock_held_ready", 2'b00);
            check("lock_held_abort", lock_abort, 1'b0);
            tick();
        end
        drive0(1, 0, 4'd3, 0, 0);
        check_ready("lock_release", 2'b01);
        push(1'b0, 16'h0064);
        tick();
        drive0(0, 0, 0, 0, 0);
        check_ready("after_release_p1", 2'b10);
        push(1'b1, 16'h2222);
        tick();
        drive1(0, 0, 0, 0, 0);
`endif
        repeat (4) tick();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
